// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - instruction register types and the shared execute function
package instr_register_pkg;

    localparam int REG_DEPTH = 32;
    localparam int ADDR_W    = $clog2(REG_DEPTH);

    typedef enum logic [3:0] {
        ZERO     = 4'd0,
        PASSTHRU = 4'd1,
        ADD      = 4'd2,
        SUB      = 4'd3,
        MULT     = 4'd4,
        DIV      = 4'd5,
        MOD      = 4'd6
    } opcode_t;

    typedef logic signed [31:0]  operand_t;
    typedef logic [ADDR_W-1:0]   address_t;
    typedef logic signed [63:0]  result_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
    } instruction_t;

    typedef struct packed {
        result_t value;
        logic    err;
    } exec_result_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HOLD  = 2'd3
    } seq_state_t;

    // Operands are widened to 64 bits first so MULT and DIV overflow cases stay exact.
    function automatic exec_result_t exec_op(instruction_t instr);
        result_t      a;
        result_t      b;
        exec_result_t r;
        a       = {{32{instr.operand_a[31]}}, instr.operand_a};
        b       = {{32{instr.operand_b[31]}}, instr.operand_b};
        r.value = '0;
        r.err   = 1'b0;
        case (instr.opcode)
            ZERO:     r.value = '0;
            PASSTHRU: r.value = a;
            ADD:      r.value = a + b;
            SUB:      r.value = a - b;
            MULT:     r.value = a * b;
            DIV: begin
                if (b == 0) r.err = 1'b1;
                else        r.value = a / b;
            end
            MOD: begin
                if (b == 0) r.err = 1'b1;
                else        r.value = a % b;
            end
            default:  r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_exec_sequencer_alu.sv
// rtl/instr_exec_sequencer_alu.sv - registered one-cycle execute stage
module instr_alu
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  instruction_t instr,
    input  address_t     addr,
    output result_t      res_value,
    output logic         res_err,
    output opcode_t      res_opcode,
    output address_t     res_addr
);

    result_t      value_q, value_d;
    logic         err_q, err_d;
    opcode_t      opcode_q, opcode_d;
    address_t     addr_q, addr_d;
    exec_result_t r;

    always_comb begin
        r        = exec_op(instr);
        value_d  = value_q;
        err_d    = err_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        if (en) begin
            value_d  = r.value;
            err_d    = r.err;
            opcode_d = instr.opcode;
            addr_d   = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q  <= '0;
            err_q    <= 1'b0;
            opcode_q <= ZERO;
            addr_q   <= '0;
        end else begin
            value_q  <= value_d;
            err_q    <= err_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
        end
    end

    assign res_value  = value_q;
    assign res_err    = err_q;
    assign res_opcode = opcode_q;
    assign res_addr   = addr_q;

endmodule

// File: rtl/instr_exec_sequencer.sv
// rtl/instr_exec_sequencer.sv - walks the register read port over a range and presents results
module instr_exec_sequencer
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     first_addr,
    input  address_t     last_addr,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output address_t     res_addr,
    output opcode_t      res_opcode,
    output result_t      res_value,
    output logic         res_err,
    output logic         busy,
    output logic         done
);

    seq_state_t   state_q, state_d;
    address_t     ptr_q, ptr_d;
    address_t     last_q, last_d;
    instruction_t instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        instr_d = instr_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d  = last_addr;
                    ptr_d   = first_addr;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = instruction_word;
                state_d = S_EXEC;
            end
            S_EXEC: state_d = S_HOLD;
            S_HOLD: begin
                if (res_ready) begin
                    if (ptr_q == last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = (ptr_q == address_t'(NUM_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status flags follow the next state so they leave the flops aligned with it.
        valid_d = (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    instr_alu u_alu (
        .clk        (clk),
        .reset      (reset),
        .en         (state_q == S_EXEC),
        .instr      (instr_q),
        .addr       (ptr_q),
        .res_value  (res_value),
        .res_err    (res_err),
        .res_opcode (res_opcode),
        .res_addr   (res_addr)
    );

    assign read_pointer = ptr_q;
    assign res_valid    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// tb/tb_instr_exec_sequencer.sv - randomized self-checking bench for instr_exec_sequencer
module tb_instr_exec_sequencer;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    address_t     first_addr;
    address_t     last_addr;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    address_t     res_addr;
    opcode_t      res_opcode;
    result_t      res_value;
    logic         res_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int           n_vec  = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_sequencer #(.NUM_ENTRIES(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .last_addr        (last_addr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_addr         (res_addr),
        .res_opcode       (res_opcode),
        .res_value        (res_value),
        .res_err          (res_err),
        .busy             (busy),
        .done             (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain integer arithmetic on the instruction as written.
    function automatic void ref_model(input instruction_t ins, output longint v, output bit e);
        longint a;
        longint b;
        a = longint'(signed'(ins.operand_a));
        b = longint'(signed'(ins.operand_b));
        v = 0;
        e = 1'b0;
        case (ins.opcode)
            ZERO:     v = 0;
            PASSTHRU: v = a;
            ADD:      v = a + b;
            SUB:      v = a - b;
            MULT:     v = a * b;
            DIV:      if (b == 0) e = 1'b1; else v = a / b;
            MOD:      if (b == 0) e = 1'b1; else v = a % b;
            default:  e = 1'b1;
        endcase
    endfunction

    function automatic operand_t rand_operand();
        case ($urandom_range(0, 3))
            0:       return operand_t'($urandom);
            1:       return operand_t'($signed($urandom_range(0, 16)) - 8);
            2:       return operand_t'(0);
            default: return operand_t'(32'h8000_0000);
        endcase
    endfunction

    task automatic rand_fill();
        for (int i = 0; i < 32; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 9));
            mem[i].opcode    = opcode_t'(o);
            mem[i].operand_a = rand_operand();
            mem[i].operand_b = rand_operand();
        end
    endtask

    // One full run; returns in the cycle where done should be high.
    task automatic do_run(input int f, input int l, input int ready_pct, input int stall_n, input bit poke);
        int           addrs[$];
        int           a;
        int           idx;
        int           cyc;
        int           last_hs;
        int           budget;
        int           stalls;
        bit           in_hold;
        bit           rdy;
        logic [63:0]  snap_v;
        logic [4:0]   snap_a;
        instruction_t ins;
        longint       ev;
        bit           ee;
        a = f;
        while (1) begin
            addrs.push_back(a);
            if (a == l) break;
            a = (a + 1) % 32;
        end
        start      = 1'b1;
        first_addr = address_t'(f);
        last_addr  = address_t'(l);
        step();
        start      = 1'b0;
        first_addr = address_t'($urandom);
        last_addr  = address_t'($urandom);
        chk("busy_at_start", busy, 1);
        chk("rp_at_start", read_pointer, f);
        chk("done_after_start", done, 0);
        cyc = 0; last_hs = 0; idx = 0; budget = 0; stalls = 0; in_hold = 0;
        snap_v = '0; snap_a = '0;
        while (idx < addrs.size()) begin
            if (budget++ > 2000) begin
                chk("timeout", 0, 1);
                break;
            end
            start = poke && (cyc == 4);
            if (poke && cyc == 4) begin
                first_addr = address_t'(f + 9);
                last_addr  = address_t'(f + 20);
            end
            if (res_valid) begin
                if (!in_hold) begin
                    in_hold = 1;
                    chk("valid_latency", cyc - last_hs, 2);
                    ins = mem[addrs[idx]];
                    ref_model(ins, ev, ee);
                    chk("res_addr", res_addr, addrs[idx]);
                    chk("res_value", res_value, ev);
                    chk("res_err", res_err, ee);
                    chk("res_opcode", res_opcode, ins.opcode);
                    snap_v = res_value;
                    snap_a = res_addr;
                    stalls = 0;
                end else begin
                    chk("stable_value", res_value, snap_v);
                    chk("stable_addr", res_addr, snap_a);
                end
                rdy = (stalls >= stall_n) && ($urandom_range(0, 99) < ready_pct);
                if (!rdy) stalls++;
            end else begin
                rdy = 1'($urandom);
            end
            chk("busy_in_run", busy, 1);
            chk("done_in_run", done, 0);
            res_ready = rdy;
            step();
            cyc++;
            if (in_hold && rdy) begin
                idx++;
                in_hold = 0;
                last_hs = cyc;
            end
        end
        start     = 1'b0;
        res_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", res_valid, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rp"}, read_pointer, 0);
        chk({tag, "_value"}, res_value, 0);
        chk({tag, "_err"}, res_err, 0);
        chk({tag, "_addr"}, res_addr, 0);
        chk({tag, "_opcode"}, res_opcode, ZERO);
    endtask

    initial begin
        int waitc;
        reset = 1'b1; start = 1'b0; res_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        rand_fill();
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b0;
        step();
        chk_reset_state("idle");

        mem[0] = '{opcode: ADD,      operand_a: 5,  operand_b: 3};
        mem[1] = '{opcode: SUB,      operand_a: 5,  operand_b: 8};
        mem[2] = '{opcode: MULT,     operand_a: -4, operand_b: 7};
        mem[3] = '{opcode: PASSTHRU, operand_a: 9,  operand_b: 0};
        mem[4] = '{opcode: DIV,      operand_a: 7,  operand_b: 0};
        mem[5] = '{opcode: MOD,      operand_a: -7, operand_b: 2};
        mem[6] = '{opcode: DIV,      operand_a: -7, operand_b: 2};
        do_run(0, 3, 100, 0, 1'b0);
        do_run(4, 6, 100, 0, 1'b0);
        do_run(30, 1, 100, 0, 1'b0);
        do_run(8, 9, 100, 5, 1'b0);
        do_run(10, 13, 100, 0, 1'b1);
        do_run(7, 7, 100, 0, 1'b0);
        do_run(5, 4, 80, 0, 1'b0);

        start = 1'b1; first_addr = 5'd2; last_addr = 5'd5;
        step();
        start = 1'b0; res_ready = 1'b0;
        waitc = 0;
        while (!res_valid && waitc < 10) begin
            step();
            waitc++;
        end
        chk("reach_hold", res_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("hold_reset");
        step();
        chk("no_done_after_reset", done, 0);
        chk("idle_after_reset", busy, 0);
        do_run(2, 5, 100, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            if (r % 5 == 0) rand_fill();
            do_run($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(30, 100), 0, 1'($urandom));
        end
        step();
        chk("done_one_cycle", done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
